// File: rtl/pipe_ctrl_seq_if.sv
// Hazard-in / strobe-out bundle between the pipeline control sequencer and the datapath registers.
// Latency: none; plain wires.
// Backpressure: the strobes themselves are the backpressure (enables low = hold, flush high = bubble).
// Ports (master = sequencer side):
//   in  : if_id_rs1/rs2, id_ex_rd, id_ex_mem_read, ex_branch_taken, dmem_req, dmem_ready
//   out : pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
//         mem_wb_flush, mem_timeout, stall_cnt, flush_cnt
interface pipe_ctrl_seq_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_mem_read;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  if_id_rs1, if_id_rs2, id_ex_rd, id_ex_mem_read, ex_branch_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    output if_id_rs1, if_id_rs2, id_ex_rd, id_ex_mem_read, ex_branch_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_seq.sv
// Pipeline control sequencer: hazard terms -> per-register enable/flush strobes for a 5-stage RV32 core.
// Latency: strobes are combinational (0 cycles); counters and watchdog flag update on the next edge.
// Backpressure: a data-memory wait freezes PC..EX/MEM and bubbles MEM/WB; a watchdog timeout freezes all.
// Ports: clk, rst (async, active high); bus (pipe_ctrl_seq_if.master) carries hazard inputs,
//   register strobes, the sticky mem_timeout flag and the saturating stall/flush counters.
module pipe_ctrl_seq #(
  parameter int STARTUP_CYCLES = 2,
  parameter int TIMEOUT        = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_seq_if.master  bus
);

  localparam int SU_W   = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [SU_W-1:0]   SU_LAST   = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SU_W-1:0]   su_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic busy;
  logic lu;
  logic squash;
  logic stall_inc;
  logic wd_trip;

  logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic if_id_flush_c, id_ex_flush_c, mem_wb_flush_c;

  assign busy = bus.dmem_req & ~bus.dmem_ready;
  assign lu   = bus.id_ex_mem_read & (bus.id_ex_rd != 5'd0) &
                ((bus.id_ex_rd == bus.if_id_rs1) | (bus.id_ex_rd == bus.if_id_rs2));

  // The counter already holds the number of earlier busy cycles in this run, so
  // the TIMEOUT-th consecutive busy cycle is the one whose edge raises the flag.
  assign wd_trip = (state_q != INIT) & busy & (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d        = state_q;
    pc_en_c        = 1'b1;
    if_id_en_c     = 1'b1;
    id_ex_en_c     = 1'b1;
    ex_mem_en_c    = 1'b1;
    mem_wb_en_c    = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    mem_wb_flush_c = 1'b0;
    squash         = 1'b0;

    case (state_q)
      INIT:     if (su_cnt_q == SU_LAST) state_d = RUN;
      RUN:      if (busy) state_d = MEM_WAIT;
      MEM_WAIT: if (!busy) state_d = RUN;
      default:  state_d = INIT;
    endcase

    if (state_q == INIT) begin
      pc_en_c        = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else if (timeout_q) begin
      // Dead pipeline: nothing moves and nothing is overwritten until reset.
      pc_en_c        = 1'b0;
      if_id_en_c     = 1'b0;
      id_ex_en_c     = 1'b0;
      ex_mem_en_c    = 1'b0;
      mem_wb_en_c    = 1'b0;
    end else if (busy) begin
      pc_en_c        = 1'b0;
      if_id_en_c     = 1'b0;
      id_ex_en_c     = 1'b0;
      ex_mem_en_c    = 1'b0;
      mem_wb_flush_c = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // pc_en stays high so the branch target is fetched this edge.
      squash         = 1'b1;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
    end else if (lu) begin
      pc_en_c        = 1'b0;
      if_id_en_c     = 1'b0;
      id_ex_flush_c  = 1'b1;
    end
  end

  assign stall_inc = (state_q != INIT) & ~pc_en_c & ~timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      su_cnt_q   <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == INIT && su_cnt_q != SU_LAST)
        su_cnt_q <= su_cnt_q + 1'b1;

      // Counts the current run of busy cycles, including the one that enters
      // MEM_WAIT; any non-busy cycle ends the run.
      if (state_q == INIT || !busy)
        wait_cnt_q <= '0;
      else if (wait_cnt_q != WAIT_MAX)
        wait_cnt_q <= wait_cnt_q + 1'b1;

      if (wd_trip)
        timeout_q <= 1'b1;

      if (stall_inc && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + 1'b1;

      if (squash && flush_q != {CNT_W{1'b1}})
        flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_en        = pc_en_c;
  assign bus.if_id_en     = if_id_en_c;
  assign bus.id_ex_en     = id_ex_en_c;
  assign bus.ex_mem_en    = ex_mem_en_c;
  assign bus.mem_wb_en    = mem_wb_en_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_flush  = id_ex_flush_c;
  assign bus.mem_wb_flush = mem_wb_flush_c;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Testbench for pipe_ctrl_seq: directed scenarios plus randomized traffic against a cycle-level reference model.
// Latency: checks strobes mid-cycle, counters/flag 1 time unit after each edge.
// Backpressure: n/a (bench drives all hazard inputs).
module tb_pipe_ctrl_seq;
  localparam int SU  = 2;
  localparam int TO  = 8;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  // Strobe vector order: pc, if_id, id_ex, ex_mem, mem_wb enables, then if_id, id_ex, mem_wb flushes.
  localparam logic [7:0] S_INIT   = 8'h7F;
  localparam logic [7:0] S_FROZEN = 8'h00;
  localparam logic [7:0] S_FREEZE = 8'h09;
  localparam logic [7:0] S_SQUASH = 8'hFE;
  localparam logic [7:0] S_BUBBLE = 8'h3A;
  localparam logic [7:0] S_RUN    = 8'hF8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_seq_if #(.CNT_W(CW)) bus ();

  pipe_ctrl_seq #(.STARTUP_CYCLES(SU), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: cycles since reset release, length of current busy run,
  // sticky timeout, and the two event tallies.
  int m_since, m_run, m_stall, m_flush;
  bit m_to;

  function automatic logic [7:0] obs();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
  endfunction

  function automatic bit m_busy();
    return bus.dmem_req && !bus.dmem_ready;
  endfunction

  function automatic bit m_lu();
    return bus.id_ex_mem_read && bus.id_ex_rd != 5'd0 &&
           (bus.id_ex_rd == bus.if_id_rs1 || bus.id_ex_rd == bus.if_id_rs2);
  endfunction

  function automatic logic [7:0] m_strobes();
    if (m_since < SU)              return S_INIT;
    else if (m_to)                 return S_FROZEN;
    else if (m_busy())             return S_FREEZE;
    else if (bus.ex_branch_taken)  return S_SQUASH;
    else if (m_lu())               return S_BUBBLE;
    else                           return S_RUN;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    m_since = 0; m_run = 0; m_stall = 0; m_flush = 0; m_to = 0;
  endtask

  // Advance the model with this cycle's inputs, then move past the edge.
  task automatic tick();
    if (m_since < SU) begin
      m_since++;
    end else if (!m_to) begin
      if (m_busy()) begin
        m_run++;
        m_stall = sat(m_stall + 1);
        if (m_run >= TO) m_to = 1;
      end else begin
        m_run = 0;
        if (bus.ex_branch_taken) m_flush = sat(m_flush + 1);
        else if (m_lu())         m_stall = sat(m_stall + 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic req, input logic rdy);
    bus.if_id_rs1 = rs1; bus.if_id_rs2 = rs2; bus.id_ex_rd = rd;
    bus.id_ex_mem_read = mr; bus.ex_branch_taken = br;
    bus.dmem_req = req; bus.dmem_ready = rdy;
    #1;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic skip_startup();
    repeat (SU) tick();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (obs() !== S_INIT) $display("FAIL rst_strobes got %h want %h", obs(), S_INIT); else passed++;
    checks++; if (bus.stall_cnt !== 4'd0) $display("FAIL rst_stall got %0d want 0", bus.stall_cnt); else passed++;
    checks++; if (bus.flush_cnt !== 4'd0) $display("FAIL rst_flush got %0d want 0", bus.flush_cnt); else passed++;
    checks++; if (bus.mem_timeout !== 1'b0) $display("FAIL rst_timeout got %b want 0", bus.mem_timeout); else passed++;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < SU; k++) begin
      checks++; if (obs() !== S_INIT) $display("FAIL startup_c%0d got %h want %h", k, obs(), S_INIT); else passed++;
      tick();
    end
    checks++; if (obs() !== S_RUN) $display("FAIL first_run got %h want %h", obs(), S_RUN); else passed++;
    tick();
    checks++; if (obs() !== S_RUN) $display("FAIL second_run got %h want %h", obs(), S_RUN); else passed++;
    checks++; if (bus.stall_cnt !== 4'd0) $display("FAIL startup_stall got %0d want 0", bus.stall_cnt); else passed++;
  endtask

  task automatic test_load_use();
    apply_reset(); skip_startup();
    drive(0, 5, 5, 1, 0, 0, 0);
    checks++; if (obs() !== S_BUBBLE) $display("FAIL lu_strobes got %h want %h", obs(), S_BUBBLE); else passed++;
    tick();
    checks++; if (bus.stall_cnt !== 4'd1) $display("FAIL lu_stall got %0d want 1", bus.stall_cnt); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (obs() !== S_RUN) $display("FAIL lu_after got %h want %h", obs(), S_RUN); else passed++;
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    checks++; if (obs() !== S_RUN) $display("FAIL lu_x0 got %h want %h", obs(), S_RUN); else passed++;
    tick();
    checks++; if (bus.stall_cnt !== 4'd1) $display("FAIL lu_x0_stall got %0d want 1", bus.stall_cnt); else passed++;
  endtask

  task automatic test_branch();
    apply_reset(); skip_startup();
    drive(0, 0, 0, 0, 1, 0, 0);
    checks++; if (obs() !== S_SQUASH) $display("FAIL br_strobes got %h want %h", obs(), S_SQUASH); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.flush_cnt !== 4'd1) $display("FAIL br_flush got %0d want 1", bus.flush_cnt); else passed++;
    checks++; if (bus.stall_cnt !== 4'd0) $display("FAIL br_stall got %0d want 0", bus.stall_cnt); else passed++;
    checks++; if (obs() !== S_RUN) $display("FAIL br_after got %h want %h", obs(), S_RUN); else passed++;
    // Branch together with load-use: squash wins, counted only as a flush.
    drive(3, 0, 3, 1, 1, 0, 0);
    checks++; if (obs() !== S_SQUASH) $display("FAIL br_lu got %h want %h", obs(), S_SQUASH); else passed++;
    tick();
    checks++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd2)
      $display("FAIL br_lu_cnt got %0d/%0d want 0/2", bus.stall_cnt, bus.flush_cnt); else passed++;
  endtask

  task automatic test_mem_branch();
    apply_reset(); skip_startup();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 1, 0);
      checks++; if (obs() !== S_FREEZE) $display("FAIL memb_freeze%0d got %h want %h", k, obs(), S_FREEZE); else passed++;
      tick();
    end
    drive(0, 0, 0, 0, 1, 1, 1);
    checks++; if (obs() !== S_SQUASH) $display("FAIL memb_release got %h want %h", obs(), S_SQUASH); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.stall_cnt !== 4'd3) $display("FAIL memb_stall got %0d want 3", bus.stall_cnt); else passed++;
    checks++; if (bus.flush_cnt !== 4'd1) $display("FAIL memb_flush got %0d want 1", bus.flush_cnt); else passed++;
    checks++; if (obs() !== S_RUN) $display("FAIL memb_after got %h want %h", obs(), S_RUN); else passed++;
  endtask

  task automatic test_watchdog();
    apply_reset(); skip_startup();
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < TO; k++) begin
      checks++; if (obs() !== S_FREEZE || bus.mem_timeout !== 1'b0)
        $display("FAIL wd_pre%0d got %h/%b want %h/0", k, obs(), bus.mem_timeout, S_FREEZE); else passed++;
      tick();
    end
    checks++; if (bus.mem_timeout !== 1'b1) $display("FAIL wd_set got %b want 1", bus.mem_timeout); else passed++;
    checks++; if (obs() !== S_FROZEN) $display("FAIL wd_frozen got %h want %h", obs(), S_FROZEN); else passed++;
    drive(0, 0, 0, 0, 1, 0, 0);
    checks++; if (obs() !== S_FROZEN) $display("FAIL wd_hold got %h want %h", obs(), S_FROZEN); else passed++;
    tick();
    checks++; if (bus.mem_timeout !== 1'b1 || bus.stall_cnt !== 4'd8 || bus.flush_cnt !== 4'd0)
      $display("FAIL wd_sticky got %b/%0d/%0d want 1/8/0", bus.mem_timeout, bus.stall_cnt, bus.flush_cnt); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_timeout !== 1'b0 || obs() !== S_INIT)
      $display("FAIL wd_rst got %b/%h want 0/%h", bus.mem_timeout, obs(), S_INIT); else passed++;
    apply_reset();
  endtask

  task automatic test_mid_reset();
    apply_reset(); skip_startup();
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (5) tick();
    checks++; if (bus.stall_cnt !== 4'd5) $display("FAIL mid_stall got %0d want 5", bus.stall_cnt); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (obs() !== S_INIT || bus.stall_cnt !== 4'd0)
      $display("FAIL mid_abort got %h/%0d want %h/0", obs(), bus.stall_cnt, S_INIT); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    skip_startup();
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < TO - 1; k++) tick();
    checks++; if (bus.mem_timeout !== 1'b0) $display("FAIL mid_wd_cleared got %b want 0", bus.mem_timeout); else passed++;
    tick();
    checks++; if (bus.mem_timeout !== 1'b1) $display("FAIL mid_wd_trip got %b want 1", bus.mem_timeout); else passed++;
  endtask

  task automatic test_saturation();
    apply_reset(); skip_startup();
    drive(7, 2, 7, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      checks++; if (obs() !== S_BUBBLE) $display("FAIL sat_strobes%0d got %h want %h", k, obs(), S_BUBBLE); else passed++;
      tick();
      checks++; if (bus.stall_cnt !== CW'(sat(k))) $display("FAIL sat_cnt%0d got %0d want %0d", k, bus.stall_cnt, sat(k)); else passed++;
    end
  endtask

  task automatic test_random();
    apply_reset(); skip_startup();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        apply_reset();
        checks++; if (obs() !== S_INIT) $display("FAIL rnd_rst%0d got %h want %h", i, obs(), S_INIT); else passed++;
      end
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)));
      checks++; if (obs() !== m_strobes()) $display("FAIL rnd_strobes%0d got %h want %h", i, obs(), m_strobes()); else passed++;
      tick();
      checks++; if (bus.stall_cnt !== CW'(m_stall) || bus.flush_cnt !== CW'(m_flush) || bus.mem_timeout !== m_to)
        $display("FAIL rnd_state%0d got %0d/%0d/%b want %0d/%0d/%b", i, bus.stall_cnt, bus.flush_cnt,
                 bus.mem_timeout, m_stall, m_flush, m_to); else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_branch();
    test_watchdog();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
